// File: rtl/eaglesong_sponge_ctrl.sv
// Sponge sequencer for the Eaglesong permutation core:
// absorbs 256-bit blocks, runs the core, emits the digest.
module eaglesong_sponge_ctrl #(
   parameter int RATE_WORDS   = 8,
   parameter int STATE_WORDS  = 16,
   parameter int PERM_TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        blk_valid,
   output logic                        blk_ready,
   input  logic [32*RATE_WORDS-1:0]    blk_data,
   input  logic                        blk_last,
   output logic                        perm_start,
   output logic [32*STATE_WORDS-1:0]   perm_state_in,
   input  logic [32*STATE_WORDS-1:0]   perm_state_out,
   input  logic                        perm_done,
   output logic                        dig_valid,
   input  logic                        dig_ready,
   output logic [32*RATE_WORDS-1:0]    dig_data,
   output logic                        busy,
   output logic                        err_timeout
);

   localparam int RW = 32 * RATE_WORDS;
   localparam int SW = 32 * STATE_WORDS;
   localparam int CW = $clog2(PERM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_LO,
      WAIT_HI,
      OUT
   } state_t;

   state_t        state;
   logic [SW-1:0] st;
   logic          last;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;

   // The start cycle counts too, so the error lands
   // PERM_TIMEOUT cycles after the perm_start pulse.
   assign tmo_hit = (tmo_cnt == CW'(PERM_TIMEOUT - 2));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         st            <= '0;
         last          <= 1'b0;
         tmo_cnt       <= '0;
         blk_ready     <= 1'b0;
         perm_start    <= 1'b0;
         perm_state_in <= '0;
         dig_valid     <= 1'b0;
         dig_data      <= '0;
         busy          <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         perm_start <= 1'b0;
         unique case (state)
            IDLE: begin
               blk_ready <= !err_timeout;
               if (blk_valid && blk_ready) begin
                  st[RW-1:0] <= st[RW-1:0] ^ blk_data;
                  last       <= blk_last;
                  blk_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               perm_state_in <= st;
               perm_start    <= 1'b1;
               state         <= START;
            end
            START: begin
               tmo_cnt <= '0;
               state   <= WAIT_LO;
            end
            WAIT_LO, WAIT_HI: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (state == WAIT_HI && perm_done) begin
                  st <= perm_state_out;
                  if (last) begin
                     dig_valid <= 1'b1;
                     dig_data  <= perm_state_out[RW-1:0];
                     state     <= OUT;
                  end else begin
                     blk_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end
               end else if (tmo_hit) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (state == WAIT_LO && !perm_done) begin
                  state <= WAIT_HI;
               end
            end
            OUT: begin
               if (dig_ready) begin
                  dig_valid <= 1'b0;
                  st        <= '0;
                  blk_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Directed bench for eaglesong_sponge_ctrl with a
// behavioural core stub and a manual perm_done override.
module tb_eaglesong_sponge_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_last = 1'b0;
   logic         dig_ready = 1'b0;
   logic [255:0] blk_data = '0;
   logic         blk_ready, perm_start, perm_done;
   logic         dig_valid, busy, err_timeout;
   logic [511:0] perm_state_in, perm_state_out;
   logic [255:0] dig_data;

   logic         manual = 1'b0;
   logic         man_done = 1'b0;
   logic [511:0] man_out = '0;
   logic         stub_done = 1'b0;
   logic         stub_busy = 1'b0;
   logic [3:0]   stub_cnt = '0;
   logic [511:0] stub_out = '0;
   int           starts = 0;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [255:0] HELLO = {
      128'h0, 32'h00210A06, 32'h6F726C64,
      32'h6F2C2077, 32'h48656C6C};
   localparam logic [255:0] DIG_HELLO = {
      32'hD6727D07, 32'h3CE7EC1E, 32'hCA9F52DB,
      32'hD0E4954B, 32'h3F4DCB6B, 32'h0B43C25D,
      32'h6162D141, 32'h247E8664};
   localparam logic [255:0] BLK_B = {
      32'h88888888, 32'h77777777, 32'h66666666,
      32'h55555555, 32'h44444444, 32'h33333333,
      32'h22222222, 32'h11111111};
   localparam logic [255:0] DIG_B = {
      32'hA5A50007, 32'h2D2D888E, 32'hD2D27772,
      32'hC3C36662, 32'hF0F05556, 32'hE1E14446,
      32'h96963332, 32'h87872222};
   localparam logic [255:0] DIG_ONES = {
      32'hA5A50007, 32'h5A5AFFF9, 32'h5A5AFFFA,
      32'h5A5AFFFB, 32'h5A5AFFFC, 32'h5A5AFFFD,
      32'h5A5AFFFE, 32'h5A5AFFFF};

   assign perm_done      = manual ? man_done : stub_done;
   assign perm_state_out = manual ? man_out : stub_out;

   eaglesong_sponge_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .blk_data       (blk_data),
      .blk_last       (blk_last),
      .perm_start     (perm_start),
      .perm_state_in  (perm_state_in),
      .perm_state_out (perm_state_out),
      .perm_done      (perm_done),
      .dig_valid      (dig_valid),
      .dig_ready      (dig_ready),
      .dig_data       (dig_data),
      .busy           (busy),
      .err_timeout    (err_timeout)
   );

   always #5 clk = ~clk;

   // Stand-in permutation: the hello state maps to the known
   // Eaglesong digest, anything else to a word rotate/xor mix.
   function automatic logic [511:0] perm_model(input logic [511:0] s);
      logic [511:0] r;
      r = '0;
      if (s == {256'h0, HELLO}) begin
         r = {{8{32'hC0FFEE00}}, DIG_HELLO};
      end else begin
         for (int i = 0; i < 16; i++)
            r[32*i +: 32] = s[32*((i+1)%16) +: 32]
                            ^ (32'hA5A50000 + 32'(i));
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (perm_start) begin
         starts    <= starts + 1;
         stub_busy <= 1'b1;
         stub_cnt  <= '0;
         stub_done <= 1'b0;
         stub_out  <= perm_model(perm_state_in);
      end else if (stub_busy) begin
         stub_cnt <= stub_cnt + 4'd1;
         if (stub_cnt == 4'd4) begin
            stub_done <= 1'b1;
            stub_busy <= 1'b0;
         end
      end
   end

   task automatic chk1(input string name, input logic act,
                       input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act,
                       input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [255:0] d, input logic l,
                       output logic [511:0] pin);
      int k;
      k = 0;
      while (!blk_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk1("blk_ready_wait", blk_ready, 1'b1);
      blk_valid = 1'b1;
      blk_data  = d;
      blk_last  = l;
      @(negedge clk);
      blk_valid = 1'b0;
      chk1("perm_start_early", perm_start, 1'b0);
      chk1("busy_load", busy, 1'b1);
      @(negedge clk);
      chk1("perm_start_pulse", perm_start, 1'b1);
      pin = perm_state_in;
   endtask

   task automatic wait_dig(output logic [255:0] d);
      int k;
      k = 0;
      while (!dig_valid && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk1("dig_valid_wait", dig_valid, 1'b1);
      d = dig_data;
   endtask

   task automatic take();
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
      chk1("dig_valid_drop", dig_valid, 1'b0);
      chk1("idle_ready", blk_ready, 1'b1);
   endtask

   typedef struct {
      logic [255:0] data;
      logic [255:0] dig;
   } vec_t;

   vec_t         tbl[3];
   logic [511:0] pin, e1, e2;
   logic [255:0] d;
   int           base;
   logic         flag;

   initial begin
      tbl[0] = '{HELLO, DIG_HELLO};
      tbl[1] = '{BLK_B, DIG_B};
      tbl[2] = '{{256{1'b1}}, DIG_ONES};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rst_blk_ready", blk_ready, 1'b0);
      chk1("rst_dig_valid", dig_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err_timeout, 1'b0);
      chk1("rst_perm_start", perm_start, 1'b0);
      chkw("rst_state_in", perm_state_in, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("post_rst_ready", blk_ready, 1'b1);

      for (int i = 0; i < 3; i++) begin
         base = starts;
         push(tbl[i].data, 1'b1, pin);
         chkw($sformatf("v%0d_state_in", i), pin,
              {256'h0, tbl[i].data});
         wait_dig(d);
         chkw($sformatf("v%0d_digest", i), {256'h0, d},
              {256'h0, tbl[i].dig});
         take();
         chki($sformatf("v%0d_starts", i), starts - base, 1);
      end

      base = starts;
      push(BLK_B, 1'b0, pin);
      chkw("two_state_in1", pin, {256'h0, BLK_B});
      push(HELLO, 1'b1, pin);
      e1 = perm_model({256'h0, BLK_B});
      e2 = e1 ^ {256'h0, HELLO};
      chkw("two_state_in2", pin, e2);
      e1 = perm_model(e2);
      wait_dig(d);
      chkw("two_digest", {256'h0, d}, {256'h0, e1[255:0]});
      take();
      chki("two_starts", starts - base, 2);

      push(HELLO, 1'b1, pin);
      wait_dig(d);
      chkw("bp_digest", {256'h0, d}, {256'h0, DIG_HELLO});
      flag = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dig_data !== DIG_HELLO || !dig_valid || blk_ready)
            flag = 1'b0;
      end
      chk1("bp_stable", flag, 1'b1);
      blk_valid = 1'b1;
      blk_data  = HELLO;
      blk_last  = 1'b1;
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
      chk1("bp_idle_busy", busy, 1'b0);
      chk1("bp_idle_ready", blk_ready, 1'b1);
      @(negedge clk);
      blk_valid = 1'b0;
      chk1("bp_held_accept", busy, 1'b1);
      @(negedge clk);
      chk1("bp_start", perm_start, 1'b1);
      chkw("bp_cleared_in", perm_state_in, {256'h0, HELLO});
      wait_dig(d);
      chkw("bp_digest2", {256'h0, d}, {256'h0, DIG_HELLO});
      take();

      manual   = 1'b1;
      man_done = 1'b1;
      man_out  = {16{32'hDEADBEEF}};
      push(BLK_B, 1'b1, pin);
      repeat (2) @(negedge clk);
      chk1("stale_busy", busy, 1'b1);
      chk1("stale_no_dig", dig_valid, 1'b0);
      man_done = 1'b0;
      man_out  = perm_model({256'h0, BLK_B});
      repeat (3) @(negedge clk);
      chk1("stale_wait", dig_valid, 1'b0);
      man_done = 1'b1;
      wait_dig(d);
      chkw("stale_digest", {256'h0, d}, {256'h0, DIG_B});
      take();

      man_done = 1'b0;
      push(HELLO, 1'b1, pin);
      repeat (3) @(negedge clk);
      chk1("mid_busy", busy, 1'b1);
      rst_n    = 1'b0;
      man_done = 1'b1;
      @(negedge clk);
      chk1("mid_rst_ready", blk_ready, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_dig", dig_valid, 1'b0);
      chkw("mid_rst_in", perm_state_in, '0);
      chkw("mid_rst_dd", {256'h0, dig_data}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("mid_idle_ready", blk_ready, 1'b1);
      @(negedge clk);
      chk1("mid_done_ignored", dig_valid, 1'b0);

      man_done = 1'b0;
      push(BLK_B, 1'b1, pin);
      flag = 1'b0;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         if (err_timeout) flag = 1'b1;
      end
      chk1("tmo_not_early", flag, 1'b0);
      @(negedge clk);
      chk1("tmo_err", err_timeout, 1'b1);
      chk1("tmo_busy", busy, 1'b0);
      blk_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk1("tmo_ready_low", blk_ready, 1'b0);
      chk1("tmo_not_taken", busy, 1'b0);
      blk_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk1("tmo_rst_err", err_timeout, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("tmo_rst_ready", blk_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
